// File: rtl/rv32_csr_pkg.sv
// Shared types and constants for the CSR access arbiter and its write-data ALU.
package rv32_csr_pkg;

  // Pipeline write-op encodings (11 is never issued)
  localparam logic [1:0] WRITE_OP_RW = 2'b00;
  localparam logic [1:0] WRITE_OP_RS = 2'b01;
  localparam logic [1:0] WRITE_OP_RC = 2'b10;

  // A few well-known CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;

  // addr[11:10] == 2'b11 marks the read-only (counter) space
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic {OWNER_PIPE, OWNER_DBG} owner_t;

  function automatic logic is_read_only(input logic [11:0] addr);
    return addr[11:10] == CSR_RO_PREFIX;
  endfunction

endpackage

// File: rtl/rv32_csr_wdata_alu.sv
// New CSR value from (op, old value, operand). Debug writes reuse it with op = RW.
module rv32_csr_wdata_alu
  import rv32_csr_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] old_value,
  input  logic [31:0] operand,
  output logic [31:0] new_value
);

  // RW replaces, RS sets bits, RC clears bits
  always_comb begin
    new_value = operand;
    case (op)
      WRITE_OP_RS: new_value = old_value | operand;
      WRITE_OP_RC: new_value = old_value & ~operand;
      default:     new_value = operand;
    endcase
  end

endmodule

// File: rtl/rv32_csr_arbiter.sv
// Arbitrates the single CSR-file port between the pipeline and the debug unit,
// running each access as a registered read followed by a conditional write.
//
// state | meaning
// IDLE  | pick an owner, latch its request
// READ  | strobe read, capture old value and hit
// WRITE | judge legality, strobe write if allowed
// DONE  | pulse owner's done/ack with old value and illegal/err
module rv32_csr_arbiter
  import rv32_csr_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid_in,
  input  logic [11:0] pipe_csr_in,
  input  logic        pipe_write_in,
  input  logic [1:0]  pipe_write_op_in,
  input  logic [31:0] pipe_operand_in,
  output logic        pipe_stall_out,
  output logic        pipe_done_out,
  output logic [31:0] pipe_rdata_out,
  output logic        pipe_illegal_out,
  input  logic        dbg_req_in,
  input  logic [11:0] dbg_csr_in,
  input  logic        dbg_we_in,
  input  logic [31:0] dbg_wdata_in,
  output logic        dbg_ack_out,
  output logic [31:0] dbg_rdata_out,
  output logic        dbg_err_out,
  output logic [11:0] csr_addr_out,
  output logic        csr_read_out,
  output logic        csr_write_out,
  output logic [31:0] csr_wdata_out,
  input  logic [31:0] csr_rdata_in,
  input  logic        csr_hit_in
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  owner_t      owner_q;
  logic [11:0] addr_q;
  logic [1:0]  op_q;
  logic [31:0] operand_q;
  logic        write_q;
  logic [31:0] rdata_q;
  logic        hit_q;
  logic        illegal_q;
  logic [3:0]  starve_q;

  logic        grant_pipe;
  logic        grant_dbg;
  logic        illegal_w;
  logic [31:0] alu_result;
  logic        done_now;

  rv32_csr_wdata_alu u_alu (
    .op        (op_q),
    .old_value (rdata_q),
    .operand   (operand_q),
    .new_value (alu_result)
  );

  assign illegal_w = !hit_q || (write_q && is_read_only(addr_q));

  // Next-state and grant decision; debug only wins on its own or once starved
  always_comb begin
    state_d    = state_q;
    grant_pipe = 1'b0;
    grant_dbg  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dbg_req_in && (!pipe_valid_in || starve_q == STARVE_MAX)) begin
          grant_dbg = 1'b1;
          state_d   = READ;
        end else if (pipe_valid_in) begin
          grant_pipe = 1'b1;
          state_d    = READ;
        end
      end
      READ:    state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and per-access latches
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_PIPE;
      addr_q    <= '0;
      op_q      <= WRITE_OP_RW;
      operand_q <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_pipe) begin
        owner_q   <= OWNER_PIPE;
        addr_q    <= pipe_csr_in;
        op_q      <= pipe_write_op_in;
        operand_q <= pipe_operand_in;
        write_q   <= pipe_write_in;
      end else if (grant_dbg) begin
        owner_q   <= OWNER_DBG;
        addr_q    <= dbg_csr_in;
        op_q      <= WRITE_OP_RW;
        operand_q <= dbg_wdata_in;
        write_q   <= dbg_we_in;
      end
      if (state_q == READ) begin
        rdata_q <= csr_rdata_in;
        hit_q   <= csr_hit_in;
      end
      if (state_q == WRITE) begin
        illegal_q <= illegal_w;
      end
    end
  end

  // Starvation counter: counts pipeline wins over a waiting debug request
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (grant_dbg || !dbg_req_in) begin
        starve_q <= '0;
      end else if (grant_pipe && starve_q != STARVE_MAX) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end

  // Strobes are masked by reset so an access aborted mid-flight never writes
  always_comb begin
    done_now         = (state_q == DONE);
    csr_addr_out     = addr_q;
    csr_read_out     = (state_q == READ) && !reset;
    csr_write_out    = (state_q == WRITE) && write_q && !illegal_w && !reset;
    csr_wdata_out    = ((state_q == WRITE) && !reset) ? alu_result : '0;
    pipe_done_out    = done_now && (owner_q == OWNER_PIPE);
    pipe_rdata_out   = pipe_done_out ? rdata_q : '0;
    pipe_illegal_out = pipe_done_out && illegal_q;
    dbg_ack_out      = done_now && (owner_q == OWNER_DBG);
    dbg_rdata_out    = dbg_ack_out ? rdata_q : '0;
    dbg_err_out      = dbg_ack_out && illegal_q;
    pipe_stall_out   = pipe_valid_in && !pipe_done_out;
  end

endmodule
